// File: rtl/mips_fetch_pkg.sv
// -----------------------------------------------------------------------------
// mips_fetch_pkg
// Shared definitions for the MIPS instruction-fetch stage:
//   - fetch_state_e     : fetch FSM states (request / wait for word / hold in skid)
//   - RESET_PC_DEFAULT  : default PC after reset
//   - NOP_WORD_DEFAULT  : default IF/ID filler word (sll $0,$0,0)
//   - OP_* / FUNCT_*    : bit positions of the opcode and function fields
// -----------------------------------------------------------------------------
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;

endpackage

// File: rtl/fetch_skid_buffer.sv
// -----------------------------------------------------------------------------
// fetch_skid_buffer
// One-entry holding register for an instruction word (and its PC+4) that came
// back from memory while the pipeline was stalled.
// Ports:
//   clk      in   rising-edge clock
//   rst_ni   in   asynchronous active-low reset (empties the entry)
//   load_i   in   capture word_i/pc4_i and mark the entry valid
//   drop_i   in   invalidate the entry (wins over load_i)
//   word_i   in   instruction word to hold
//   pc4_i    in   PC+4 belonging to word_i
//   valid_o  out  entry holds a word
//   word_o   out  held instruction word
//   pc4_o    out  held PC+4
// -----------------------------------------------------------------------------
module fetch_skid_buffer (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        drop_i,
    input  logic [31:0] word_i,
    input  logic [31:0] pc4_i,
    output logic        valid_o,
    output logic [31:0] word_o,
    output logic [31:0] pc4_o
);

    logic        valid_q, valid_d;
    logic [31:0] word_q;
    logic [31:0] pc4_q;

    always_comb begin
        valid_d = valid_q;
        if (drop_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load_i) begin
            word_q <= word_i;
            pc4_q  <= pc4_i;
        end
    end

    assign valid_o = valid_q;
    assign word_o  = word_q;
    assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the MIPS core. Owns the PC, issues one word read
// at a time to instruction memory (valid/ready request, valid-only in-order
// response), and fills the IF/ID register consumed by decode/control.
// Honours Stall from the hazard unit and Redirect from the execute stage.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : a redirect to a non-word-aligned target sets the sticky
//               MisalignFault flag (cleared only by reset).
//   undefined : MisalignFault is tied to 0.
//   In both builds the PC is loaded with the target's low two bits cleared.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   Stall         in   hold IF/ID and PC
//   Redirect      in   load RedirectPC, flush IF/ID, abandon any fetch in flight
//   RedirectPC    in   redirect target address
//   ImemReqValid  out  request valid (address on ImemAddr)
//   ImemReqReady  in   memory accepts the request this cycle
//   ImemAddr      out  byte address of the request (= PC)
//   ImemRspValid  in   ImemRdata valid
//   ImemRdata     in   returned instruction word
//   IFID_Valid    out  IF/ID holds a live instruction
//   Instruction   out  IF/ID instruction word
//   PC_4          out  PC+4 of the IF/ID instruction
//   OP            out  Instruction[31:26]
//   Function      out  Instruction[5:0]
//   MisalignFault out  sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module fetch_stage
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        ImemReqValid,
    input  logic        ImemReqReady,
    output logic [31:0] ImemAddr,
    input  logic        ImemRspValid,
    input  logic [31:0] ImemRdata,
    output logic        IFID_Valid,
    output logic [31:0] Instruction,
    output logic [31:0] PC_4,
    output logic [5:0]  OP,
    output logic [5:0]  Function,
    output logic        MisalignFault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         kill_q, kill_d;
    logic         ifid_valid_q, ifid_valid_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc4_q, pc4_d;

    logic         skid_load, skid_drop, skid_valid;
    logic [31:0]  skid_word, skid_pc4;

    logic [31:0]  pc_plus4;
    logic [31:0]  redirect_pc;

    assign pc_plus4    = pc_q + 32'd4;
    assign redirect_pc = RedirectPC & ~32'h3;

    fetch_skid_buffer u_skid (
        .clk     (clk),
        .rst_ni  (reset),
        .load_i  (skid_load),
        .drop_i  (skid_drop),
        .word_i  (ImemRdata),
        .pc4_i   (pc_plus4),
        .valid_o (skid_valid),
        .word_o  (skid_word),
        .pc4_o   (skid_pc4)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        // Without a load, a non-stalled cycle inserts a bubble.
        ifid_valid_d = Stall ? ifid_valid_q : 1'b0;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        skid_load    = 1'b0;
        skid_drop    = 1'b0;

        if (Redirect) begin
            pc_d         = redirect_pc;
            ifid_valid_d = 1'b0;
            instr_d      = NOP_WORD;
            skid_drop    = 1'b1;
            if (state_q == S_WAIT && ImemRspValid) begin
                // The outstanding word arrives now and is simply discarded:
                // nothing is left in flight, so no kill is needed.
                kill_d  = 1'b0;
                state_d = S_REQ;
            end else if (state_q == S_WAIT || (state_q == S_REQ && ImemReqReady)) begin
                // A request to the old path is (or is becoming) outstanding;
                // swallow its response before fetching the new target.
                kill_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                state_d = S_REQ;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (ImemReqReady) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ImemRspValid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = S_REQ;
                        end else if (!Stall) begin
                            ifid_valid_d = 1'b1;
                            instr_d      = ImemRdata;
                            pc4_d        = pc_plus4;
                            pc_d         = pc_plus4;
                            state_d      = S_REQ;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!Stall && skid_valid) begin
                        ifid_valid_d = 1'b1;
                        instr_d      = skid_word;
                        pc4_d        = skid_pc4;
                        pc_d         = pc_plus4;
                        skid_drop    = 1'b1;
                        state_d      = S_REQ;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            ifid_valid_q <= 1'b0;
            instr_q      <= NOP_WORD;
            pc4_q        <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            ifid_valid_q <= ifid_valid_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    always_comb begin
        misalign_d = misalign_q;
        if (Redirect && (RedirectPC[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign MisalignFault = misalign_q;
`else
    assign MisalignFault = 1'b0;
`endif

    // Gated by reset so no request is presented while reset is held.
    assign ImemReqValid = reset && (state_q == S_REQ);
    assign ImemAddr     = pc_q;
    assign IFID_Valid   = ifid_valid_q;
    assign Instruction  = instr_q;
    assign PC_4         = pc4_q;
    assign OP           = instr_q[OP_MSB:OP_LSB];
    assign Function     = instr_q[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Randomized bench for fetch_stage. The stimulus side plays instruction memory
// and the hazard/execute units; an architectural model (program counter that
// advances by 4 per delivered instruction and jumps on redirect) pushes the
// expected IF/ID contents into a queue. A separate monitor pops and compares
// whenever IF/ID takes a new instruction.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        ImemReqValid;
    logic        ImemReqReady;
    logic [31:0] ImemAddr;
    logic        ImemRspValid;
    logic [31:0] ImemRdata;
    logic        IFID_Valid;
    logic [31:0] Instruction;
    logic [31:0] PC_4;
    logic [5:0]  OP;
    logic [5:0]  Function;
    logic        MisalignFault;

    fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .Stall        (Stall),
        .Redirect     (Redirect),
        .RedirectPC   (RedirectPC),
        .ImemReqValid (ImemReqValid),
        .ImemReqReady (ImemReqReady),
        .ImemAddr     (ImemAddr),
        .ImemRspValid (ImemRspValid),
        .ImemRdata    (ImemRdata),
        .IFID_Valid   (IFID_Valid),
        .Instruction  (Instruction),
        .PC_4         (PC_4),
        .OP           (OP),
        .Function     (Function),
        .MisalignFault(MisalignFault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_loads = 0;
    logic [31:0] model_pc;
    bit          mis_exp;
    bit          pend;
    bit          pend_dead;
    logic [31:0] pend_addr;
    int          pend_wait;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2008_0005;   // addi
        if (a == 32'h0040_0004) return 32'h012A_4020;   // add
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    // Drive one cycle of stimulus (at the falling edge) and advance the model
    // by what must happen at the following rising edge.
    task automatic drive_cycle(input bit rdy, input bit stl, input bit rdr,
                               input logic [31:0] tgt, input int kmax);
        bit rsp;
        bit acc;
        @(negedge clk);
        rsp = pend && (pend_wait == 0);
        acc = ImemReqValid && rdy;
        ImemReqReady = rdy;
        Stall        = stl;
        Redirect     = rdr;
        RedirectPC   = tgt;
        ImemRspValid = rsp;
        ImemRdata    = rsp ? mem_word(pend_addr) : $urandom;
        if (acc) chk("one_outstanding", 32'(pend), 32'h0);
        if (rsp) begin
            if (!pend_dead && !rdr) begin
                chk("fetch_addr", pend_addr, model_pc);
                exp_q.push_back('{model_pc + 32'd4, mem_word(model_pc)});
                model_pc = model_pc + 32'd4;
            end
            pend = 1'b0;
        end
        if (rdr) begin
            exp_q.delete();
            model_pc = tgt & ~32'h3;
            if (pend) pend_dead = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
            if (tgt[1:0] != 2'b00) mis_exp = 1'b1;
`endif
        end
        if (acc) begin
            pend      = 1'b1;
            pend_addr = ImemAddr;
            pend_dead = rdr;
            pend_wait = $urandom_range(kmax - 1, 0);
        end else if (pend && !rsp) begin
            pend_wait--;
        end
    endtask

    // Monitor: compares IF/ID after every rising edge.
    initial begin : monitor
        bit          s_rst, s_stl, s_rdr;
        logic        p_valid;
        logic [31:0] p_instr, p_pc4;
        exp_t        e;
        p_valid = 1'b0;
        p_instr = NOP;
        p_pc4   = 32'h0;
        forever begin
            @(posedge clk);
            s_rst = reset;
            s_stl = Stall;
            s_rdr = Redirect;
            #1;
            if (s_rst) begin
                if (s_rdr) begin
                    chk("flush_valid", 32'(IFID_Valid), 32'h0);
                    chk("flush_instr", Instruction, NOP);
                end else if (s_stl) begin
                    chk("stall_valid", 32'(IFID_Valid), 32'(p_valid));
                    chk("stall_instr", Instruction, p_instr);
                    chk("stall_pc4", PC_4, p_pc4);
                end else if (IFID_Valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_load: got instr %h pc4 %h, expected no instruction",
                                 Instruction, PC_4);
                    end else begin
                        e = exp_q.pop_front();
                        n_loads++;
                        chk("instr", Instruction, e.word);
                        chk("pc4", PC_4, e.pc4);
                        chk("op", 32'(OP), 32'(e.word[31:26]));
                        chk("funct", 32'(Function), 32'(e.word[5:0]));
                        if (e.pc4 == 32'h0040_0004) begin
                            chk("addi_op", 32'(OP), 32'h08);
                            chk("addi_funct", 32'(Function), 32'h05);
                        end
                        if (e.pc4 == 32'h0040_0008) begin
                            chk("add_op", 32'(OP), 32'h00);
                            chk("add_funct", 32'(Function), 32'h20);
                        end
                    end
                end
                chk("misalign", 32'(MisalignFault), 32'(mis_exp));
            end
            p_valid = IFID_Valid;
            p_instr = Instruction;
            p_pc4   = PC_4;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    task automatic wait_for_pend(input bit need_delay, input int kmax);
        int n;
        n = 0;
        do begin
            drive_cycle(1'b1, 1'b0, 1'b0, 32'h0, kmax);
            n++;
        end while (!(pend && (!need_delay || pend_wait > 0)) && n < 100);
        if (n >= 100) chk("pend_timeout", 32'(n), 32'(0));
    endtask

    initial begin : stim
        int loads0;
        logic [31:0] tgt;
        reset        = 1'b1;
        Stall        = 1'b0;
        Redirect     = 1'b0;
        RedirectPC   = 32'h0;
        ImemReqReady = 1'b0;
        ImemRspValid = 1'b0;
        ImemRdata    = 32'h0;
        pend         = 1'b0;
        pend_dead    = 1'b0;
        pend_addr    = 32'h0;
        pend_wait    = 0;
        mis_exp      = 1'b0;
        model_pc     = RST_PC;
        #1 reset = 1'b0;
        #2;
        chk("rst_reqvalid", 32'(ImemReqValid), 32'h0);
        chk("rst_ifid_valid", 32'(IFID_Valid), 32'h0);
        chk("rst_instr", Instruction, NOP);
        chk("rst_pc4", PC_4, 32'h0);
        chk("rst_misalign", 32'(MisalignFault), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_addr", ImemAddr, RST_PC);
        chk("rst_reqvalid_after", 32'(ImemReqValid), 32'h1);

        // Back-to-back fetch, ready=1, k=1: one instruction every 2 cycles.
        loads0 = n_loads;
        for (int i = 0; i < 20; i++) drive_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
        drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1);
        chk("throughput", 32'(n_loads - loads0), 32'd10);

        // Response arrives during a 5-cycle stall, then release.
        wait_for_pend(1'b0, 1);
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1);
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);

        // Redirect while a slow response is outstanding.
        wait_for_pend(1'b1, 4);
        drive_cycle(1'b1, 1'b0, 1'b1, 32'h0040_0100, 4);
        for (int i = 0; i < 12; i++) drive_cycle(1'b1, 1'b0, 1'b0, 32'h0, 4);

        // Redirect, Stall and response in the same cycle.
        wait_for_pend(1'b0, 1);
        drive_cycle(1'b1, 1'b1, 1'b1, 32'h0040_0200, 1);
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);

        // PC wraps modulo 2^32.
        drive_cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1);
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);

        // Misaligned redirect target.
        drive_cycle(1'b1, 1'b0, 1'b1, 32'h0040_0102, 1);
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);

        // Asynchronous reset in the middle of a wait.
        wait_for_pend(1'b1, 4);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_reqvalid", 32'(ImemReqValid), 32'h0);
        chk("midrst_ifid_valid", 32'(IFID_Valid), 32'h0);
        chk("midrst_instr", Instruction, NOP);
        chk("midrst_pc4", PC_4, 32'h0);
        chk("midrst_misalign", 32'(MisalignFault), 32'h0);
        pend     = 1'b0;
        mis_exp  = 1'b0;
        model_pc = RST_PC;
        exp_q.delete();
        @(negedge clk);
        ImemRspValid = 1'b1;
        ImemRdata    = 32'hDEAD_BEEF;
        ImemReqReady = 1'b1;
        Stall        = 1'b0;
        Redirect     = 1'b0;
        @(negedge clk);
        ImemRspValid = 1'b0;
        ImemReqReady = 1'b0;
        reset        = 1'b1;
        #1;
        chk("restart_addr", ImemAddr, RST_PC);
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            tgt = 32'h0040_0000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
            drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                        $urandom_range(0, 15) == 0, tgt, 4);
        end

        // Drain: no stall, no new requests; everything accepted must arrive.
        for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 4);
        chk("drain_queue", 32'(exp_q.size()), 32'h0);
        chk("drain_pending", 32'(pend), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
